mem_handshake_ram: RTL

// - Byte-organised 256x8 main memory behind the MAR/MDR pair; the CPU's single memory stage for fetch, load and store.
// - Accepts one access per MOV request and answers with MOC after a fixed, parameterised latency.
// - Supports byte, halfword and word accesses in big-endian order.
// - Read data goes to the MDR/IR input mux; write data is taken from the MDR.

---
 rtl/mem_handshake_ram.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_handshake_ram.sv
// Byte-organised big-endian RAM behind the MAR/MDR pair with a MOV/MOC handshake.
// Optional MEM_ALIGN_CHECK_EN adds a misalign flag and suppresses misaligned accesses.
module mem_handshake_ram #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        m,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              MOC
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic [7:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [1:0]        m_q, m_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              moc_q, moc_d;
    logic [31:0]       dout_q, dout_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic              mis_q, mis_d;
`endif

    logic [ADDR_W-1:0] base, lane1, lane2, lane3;
    logic              bad;
    logic              complete;
    logic              we;
    logic [31:0]       rd_data;

    always_comb begin
        case (m_q)
            2'b00:   base = addr_q;
            2'b01:   base = {addr_q[ADDR_W-1:1], 1'b0};
            default: base = {addr_q[ADDR_W-1:2], 2'b00};
        endcase
        lane1 = base + ADDR_W'(1);
        lane2 = base + ADDR_W'(2);
        lane3 = base + ADDR_W'(3);
`ifdef MEM_ALIGN_CHECK_EN
        bad = ((m_q == 2'b01) && addr_q[0]) || (m_q[1] && (addr_q[1:0] != 2'b00));
`else
        bad = 1'b0;
`endif
        case (m_q)
            2'b00:   rd_data = {24'h0, mem[base]};
            2'b01:   rd_data = {16'h0, mem[base], mem[lane1]};
            default: rd_data = {mem[base], mem[lane1], mem[lane2], mem[lane3]};
        endcase
    end

    // state_q is held IDLE while reset is low, so no write can slip through an abort
    assign complete = (state_q == BUSY) && MOV && (cnt_q == 4'd0);
    assign we       = complete && !rw_q && !bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        m_d     = m_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        moc_d   = moc_q;
        dout_d  = dout_q;
`ifdef MEM_ALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    rw_d    = RW;
                    m_d     = m;
                    addr_d  = address;
                    wdata_d = data_in;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!MOV) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    moc_d   = 1'b1;
                    state_d = DONE;
`ifdef MEM_ALIGN_CHECK_EN
                    mis_d   = bad;
`endif
                    if (rw_q && !bad) begin
                        dout_d = rd_data;
                    end
                end
            end
            DONE: begin
                if (!MOV) begin
                    moc_d   = 1'b0;
                    state_d = IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    mis_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            m_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            moc_q   <= 1'b0;
            dout_q  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            m_q     <= m_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            moc_q   <= moc_d;
            dout_q  <= dout_d;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Storage is deliberately outside the reset domain so preloaded contents survive reset
    always_ff @(posedge CLK) begin
        if (we) begin
            case (m_q)
                2'b00: mem[base] <= wdata_q[7:0];
                2'b01: begin
                    mem[base]  <= wdata_q[15:8];
                    mem[lane1] <= wdata_q[7:0];
                end
                default: begin
                    mem[base]  <= wdata_q[31:24];
                    mem[lane1] <= wdata_q[23:16];
                    mem[lane2] <= wdata_q[15:8];
                    mem[lane3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign data_out = dout_q;
    assign MOC      = moc_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mis_q;
`endif

endmodule
